hazard_stall_ctrl: RTL and testbench

//   Hazard control unit. Reads the ID/EX register's MemRead/rd outputs and the IF/ID source registers.

---
 rtl/hazard_stall_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
//   Front-end hazard control for a 5-stage pipeline.
//   - Load-use hazard: holds PC and IF/ID and injects a bubble into ID/EX
//     for LOAD_STALL_CYCLES cycles.
//   - Taken branch: flushes IF/ID and ID/EX for FLUSH_CYCLES cycles
//     (detect cycle included). A branch always wins over a load-use hazard.
//   - Saturating debug counters of bubble cycles and flush events.
//
// Ports
//   clk           in   pipeline clock, posedge
//   reset         in   asynchronous reset, active low
//   IDEX_MemRead  in   instruction in EX is a load
//   IDEX_rd       in   destination register of instruction in EX
//   IFID_rs1/rs2  in   source registers of instruction in ID
//   Branch_taken  in   branch resolved taken (pulse or level)
//   clr_cnt       in   synchronous clear of both statistics counters
//   PC_Write      out  1 = PC may update
//   IFID_Write    out  1 = IF/ID may load
//   IDEX_Bubble   out  1 = zero ID/EX control inputs this cycle
//   IFID_Flush    out  1 = clear IF/ID at next edge
//   IDEX_Flush    out  1 = clear ID/EX at next edge
//   stall_cnt     out  bubble cycles issued (saturating)
//   flush_cnt     out  flush events started (saturating)
// -----------------------------------------------------------------------------
module hazard_stall_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 2,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             IDEX_MemRead,
  input  logic [4:0]       IDEX_rd,
  input  logic [4:0]       IFID_rs1,
  input  logic [4:0]       IFID_rs2,
  input  logic             Branch_taken,
  input  logic             clr_cnt,
  output logic             PC_Write,
  output logic             IFID_Write,
  output logic             IDEX_Bubble,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Down-counter must hold the larger of the two reload values.
  localparam int MAXC = (LOAD_STALL_CYCLES > FLUSH_CYCLES) ? LOAD_STALL_CYCLES : FLUSH_CYCLES;
  localparam int DW   = (MAXC < 2) ? 1 : $clog2(MAXC + 1);

  localparam logic [DW-1:0]    LOAD_RELOAD  = DW'(LOAD_STALL_CYCLES - 1);
  localparam logic [DW-1:0]    FLUSH_RELOAD = DW'(FLUSH_CYCLES - 1);
  localparam logic [DW-1:0]    CNT_ONE      = DW'(1);
  localparam logic [CNT_W-1:0] STAT_MAX     = '1;
  localparam logic [CNT_W-1:0] STAT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_STALL = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [DW-1:0]     r_cnt;
  logic [DW-1:0]     w_cnt_next;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic              w_hz;
  logic              w_pc_write;
  logic              w_ifid_write;
  logic              w_bubble;
  logic              w_flush;

  // Load-use hazard: x0 is never a real dependency.
  assign w_hz = IDEX_MemRead && (IDEX_rd != 5'd0) &&
                ((IDEX_rd == IFID_rs1) || (IDEX_rd == IFID_rs2));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and Mealy outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_pc_write   = 1'b1;
    w_ifid_write = 1'b1;
    w_bubble     = 1'b0;
    w_flush      = 1'b0;

    if (Branch_taken) begin
      // Branch wins in every state: starts, restarts, or aborts into a flush.
      w_flush = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        w_state_next = S_FLUSH;
        w_cnt_next   = FLUSH_RELOAD;
      end else begin
        w_state_next = S_RUN;
        w_cnt_next   = '0;
      end
    end else begin
      case (r_state)
        S_STALL: begin
          w_pc_write   = 1'b0;
          w_ifid_write = 1'b0;
          w_bubble     = 1'b1;
          w_cnt_next   = r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            w_state_next = S_RUN;
          end
        end
        S_FLUSH: begin
          w_flush    = 1'b1;
          w_cnt_next = r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            w_state_next = S_RUN;
          end
        end
        S_RUN: begin
          if (w_hz) begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_bubble     = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              w_state_next = S_STALL;
              w_cnt_next   = LOAD_RELOAD;
            end
          end
        end
        default: begin
          w_state_next = S_RUN;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

  // While reset is low the pipeline runs freely regardless of inputs; the
  // gating is combinational so a mid-flush reset drops Flush immediately.
  assign PC_Write    = w_pc_write   | ~reset;
  assign IFID_Write  = w_ifid_write | ~reset;
  assign IDEX_Bubble = w_bubble     &  reset;
  assign IFID_Flush  = w_flush      &  reset;
  assign IDEX_Flush  = w_flush      &  reset;

  // ---------------------------------------------------------------------------
  // Saturating statistics counters; clear wins over increment.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (clr_cnt) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (IDEX_Bubble && (r_stall_cnt != STAT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + STAT_ONE;
      end
      if (Branch_taken && (r_flush_cnt != STAT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + STAT_ONE;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_ctrl
//   Two instances share one stimulus stream:
//     dut_a: LOAD_STALL_CYCLES=1, FLUSH_CYCLES=2, CNT_W=16
//     dut_b: LOAD_STALL_CYCLES=3, FLUSH_CYCLES=3, CNT_W=4
//   The driver applies inputs just after each posedge, runs a cycle-level
//   reference model (remaining-bubble / remaining-flush counts) and queues the
//   expected outputs; a monitor pops and compares at the following negedge.
// -----------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       IDEX_MemRead = 1'b0;
  logic [4:0] IDEX_rd = '0;
  logic [4:0] IFID_rs1 = '0;
  logic [4:0] IFID_rs2 = '0;
  logic       Branch_taken = 1'b0;
  logic       clr_cnt = 1'b0;

  logic        a_pc, a_ifid, a_bub, a_iff, a_idf;
  logic [15:0] a_sc, a_fc;
  logic        b_pc, b_ifid, b_bub, b_iff, b_idf;
  logic [3:0]  b_sc, b_fc;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(2), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .IDEX_MemRead(IDEX_MemRead), .IDEX_rd(IDEX_rd),
    .IFID_rs1(IFID_rs1), .IFID_rs2(IFID_rs2), .Branch_taken(Branch_taken),
    .clr_cnt(clr_cnt), .PC_Write(a_pc), .IFID_Write(a_ifid), .IDEX_Bubble(a_bub),
    .IFID_Flush(a_iff), .IDEX_Flush(a_idf), .stall_cnt(a_sc), .flush_cnt(a_fc)
  );

  hazard_stall_ctrl #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(3), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .IDEX_MemRead(IDEX_MemRead), .IDEX_rd(IDEX_rd),
    .IFID_rs1(IFID_rs1), .IFID_rs2(IFID_rs2), .Branch_taken(Branch_taken),
    .clr_cnt(clr_cnt), .PC_Write(b_pc), .IFID_Write(b_ifid), .IDEX_Bubble(b_bub),
    .IFID_Flush(b_iff), .IDEX_Flush(b_idf), .stall_cnt(b_sc), .flush_cnt(b_fc)
  );

  // Expected word: {PC_Write, IFID_Write, Bubble, IFID_Flush, IDEX_Flush, stall_cnt, flush_cnt}
  typedef struct packed {
    logic [36:0] a;
    logic [36:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  // Reference model state per instance
  int m_lsc[2]  = '{1, 3};
  int m_fcy[2]  = '{2, 3};
  int m_max[2]  = '{65535, 15};
  int m_srem[2] = '{0, 0};
  int m_frem[2] = '{0, 0};
  int m_sc[2]   = '{0, 0};
  int m_fc[2]   = '{0, 0};

  task automatic model_step(input int k, input bit rst, input bit mr,
                            input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input bit bt, input bit clr,
                            output logic [36:0] e);
    logic [4:0] fl;
    bit         hz;
    if (!rst) begin
      m_srem[k] = 0;
      m_frem[k] = 0;
      m_sc[k]   = 0;
      m_fc[k]   = 0;
      e = {5'b11000, 16'd0, 16'd0};
      return;
    end
    hz = mr && (rd != 0) && (rd == rs1 || rd == rs2);
    if (bt) begin
      fl = 5'b11011;
      m_frem[k] = m_fcy[k] - 1;
      m_srem[k] = 0;
    end else if (m_frem[k] > 0) begin
      fl = 5'b11011;
      m_frem[k]--;
    end else if (m_srem[k] > 0) begin
      fl = 5'b00100;
      m_srem[k]--;
    end else if (hz) begin
      fl = 5'b00100;
      m_srem[k] = m_lsc[k] - 1;
    end else begin
      fl = 5'b11000;
    end
    e = {fl, 16'(m_sc[k]), 16'(m_fc[k])};
    // Counter values after the coming edge
    if (clr) begin
      m_sc[k] = 0;
      m_fc[k] = 0;
    end else begin
      if (fl[2] && m_sc[k] < m_max[k]) m_sc[k]++;
      if (bt && m_fc[k] < m_max[k]) m_fc[k]++;
    end
  endtask

  task automatic drive(input bit rst, input bit mr, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input bit bt, input bit clr);
    exp_t e;
    @(posedge clk);
    #1;
    reset        = rst;
    IDEX_MemRead = mr;
    IDEX_rd      = rd;
    IFID_rs1     = rs1;
    IFID_rs2     = rs2;
    Branch_taken = bt;
    clr_cnt      = clr;
    model_step(0, rst, mr, rd, rs1, rs2, bt, clr, e.a);
    model_step(1, rst, mr, rd, rs1, rs2, bt, clr, e.b);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
  endtask

  // Monitor: compare at each negedge when an expectation is pending
  initial begin
    exp_t        e;
    logic [36:0] act_a;
    logic [36:0] act_b;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act_a = {a_pc, a_ifid, a_bub, a_iff, a_idf, a_sc, a_fc};
        act_b = {b_pc, b_ifid, b_bub, b_iff, b_idf, 12'd0, b_sc, 12'd0, b_fc};
        n_cmp++;
        if (act_a !== e.a) begin
          n_err++;
          $display("FAIL dut_a cyc=%0d got flags=%b sc=%0d fc=%0d, want flags=%b sc=%0d fc=%0d",
                   cyc, act_a[36:32], act_a[31:16], act_a[15:0], e.a[36:32], e.a[31:16], e.a[15:0]);
        end
        n_cmp++;
        if (act_b !== e.b) begin
          n_err++;
          $display("FAIL dut_b cyc=%0d got flags=%b sc=%0d fc=%0d, want flags=%b sc=%0d fc=%0d",
                   cyc, act_b[36:32], act_b[31:16], act_b[15:0], e.b[36:32], e.b[31:16], e.b[15:0]);
        end
      end
    end
  end

  initial begin
    int wait_cyc;
    // Reset state, with hazard and branch inputs active to show forcing
    drive(0, 1, 5'd5, 5'd5, 5'd0, 0, 0);
    drive(0, 0, 5'd0, 5'd0, 5'd0, 1, 0);
    idle(2);

    // Load-use hazard, then rd=0 which must not stall
    drive(1, 1, 5'd5, 5'd5, 5'd0, 0, 0);
    idle(4);
    drive(1, 1, 5'd0, 5'd0, 5'd0, 0, 0);
    drive(1, 1, 5'd7, 5'd1, 5'd7, 0, 0);
    idle(4);

    // Branch pulse
    drive(1, 0, 5'd0, 5'd0, 5'd0, 1, 0);
    idle(4);

    // Branch and hazard together
    drive(1, 1, 5'd3, 5'd3, 5'd3, 1, 0);
    idle(4);
    // Branch arriving during a multi-cycle stall
    drive(1, 1, 5'd9, 5'd9, 5'd2, 0, 0);
    drive(1, 1, 5'd9, 5'd9, 5'd2, 1, 0);
    idle(4);
    // Branch restarting an ongoing flush
    drive(1, 0, 5'd0, 5'd0, 5'd0, 1, 0);
    drive(1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    drive(1, 0, 5'd0, 5'd0, 5'd0, 1, 0);
    idle(4);

    // Long hazard to saturate the 4-bit counter, then clear
    for (int i = 0; i < 20; i++) drive(1, 1, 5'd4, 5'd0, 5'd4, 0, 0);
    drive(1, 0, 5'd0, 5'd0, 5'd0, 0, 1);
    idle(2);

    // Async reset mid-flush
    drive(1, 0, 5'd0, 5'd0, 5'd0, 1, 0);
    drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 1) == 1),
            5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 39) == 0));
    end

    // Drain with a bounded wait
    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
